// File: rtl/display_pkg.sv
// Shared definitions for the display framebuffer: pixel geometry,
// channel placement inside a pixel word and the framebuffer FSM encodings.
package display_pkg;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam logic [1:0] FB_IDLE      = 2'd0;
  localparam logic [1:0] FB_CLEAR     = 2'd1;
  localparam logic [1:0] FB_SWAP_WAIT = 2'd2;

  function automatic int pixel_width(input int bitwidth);
    return 3 * bitwidth;
  endfunction

  // Address fields never collapse to zero width, even for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_framebuffer_if.sv
// Bundle of the read, write, command and frame-sync signals between the
// framebuffer (slave) and its driver/content source (master).
interface display_framebuffer_if #(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int BITWIDTH = 8
);
  localparam int PW = display_pkg::pixel_width(BITWIDTH);
  localparam int RW = display_pkg::clog2_min1(ROWS);
  localparam int CW = display_pkg::clog2_min1(COLUMNS);
  localparam int SW = display_pkg::clog2_min1(SEGMENTS);

  logic [RW-1:0]          rd_row;
  logic [CW-1:0]          rd_column;
  logic [PW*SEGMENTS-1:0] rd_pixel;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [SW-1:0]          wr_segment;
  logic [RW-1:0]          wr_row;
  logic [CW-1:0]          wr_column;
  logic [PW-1:0]          wr_data;
  logic                   clear_req;
  logic                   swap_req;
  logic                   cmd_ready;
  logic                   frame_complete;
  logic                   swap_done;
  logic                   active_bank;

  modport master (
    output rd_row, rd_column, wr_valid, wr_segment, wr_row, wr_column, wr_data,
           clear_req, swap_req, frame_complete,
    input  rd_pixel, wr_ready, cmd_ready, swap_done, active_bank
  );

  modport slave (
    input  rd_row, rd_column, wr_valid, wr_segment, wr_row, wr_column, wr_data,
           clear_req, swap_req, frame_complete,
    output rd_pixel, wr_ready, cmd_ready, swap_done, active_bank
  );

endinterface

// File: rtl/framebuffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on the array so it maps onto block RAM.
module framebuffer_ram #(
  parameter int WIDTH = 24,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: the front bank answers the display driver with
// one cycle of latency while the back bank is written, cleared and swapped.
module display_framebuffer
  import display_pkg::*;
#(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  display_framebuffer_if.slave  fb
);

  localparam int PW = pixel_width(BITWIDTH);
  localparam int NW = ROWS * COLUMNS;
  localparam int LW = clog2_min1(NW);
  localparam int AW = LW + 1;
  localparam logic [LW-1:0] LAST = LW'(NW - 1);

  logic [1:0]             state_q, state_d;
  logic [LW-1:0]          clr_cnt_q, clr_cnt_d;
  logic                   bank_q, bank_d;
  logic                   swap_done_q, swap_done_d;
  logic                   rd_ok_q;
  logic                   idle_s, clearing_s;
  logic                   rd_in_range_s, wr_ok_s;
  logic [LW-1:0]          rd_lin_s, wr_lin_s;
  logic [AW-1:0]          rd_addr_s, wr_addr_s;
  logic [PW*SEGMENTS-1:0] ram_q_s;

  assign idle_s     = (state_q == FB_IDLE);
  assign clearing_s = (state_q == FB_CLEAR);

  assign rd_lin_s      = LW'(fb.rd_row) * LW'(COLUMNS) + LW'(fb.rd_column);
  assign rd_in_range_s = (32'(fb.rd_row) < ROWS) && (32'(fb.rd_column) < COLUMNS);
  assign rd_addr_s     = {bank_q, rd_lin_s};

  assign wr_lin_s  = LW'(fb.wr_row) * LW'(COLUMNS) + LW'(fb.wr_column);
  assign wr_ok_s   = idle_s && fb.wr_valid && (32'(fb.wr_row) < ROWS)
                     && (32'(fb.wr_column) < COLUMNS) && (32'(fb.wr_segment) < SEGMENTS);
  assign wr_addr_s = clearing_s ? {~bank_q, clr_cnt_q} : {~bank_q, wr_lin_s};

  for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
    logic          we_s;
    logic [PW-1:0] wdata_s;

    assign we_s    = clearing_s || (wr_ok_s && (32'(fb.wr_segment) == i));
    assign wdata_s = clearing_s ? {PW{1'b0}} : fb.wr_data;

    framebuffer_ram #(
      .WIDTH (PW),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .we_i    (we_s),
      .waddr_i (wr_addr_s),
      .wdata_i (wdata_s),
      .raddr_i (rd_addr_s),
      .rdata_o (ram_q_s[i*PW +: PW])
    );
  end

  // Out-of-range reads and the post-reset cycle present zero instead of raw RAM data.
  assign fb.rd_pixel    = ram_q_s & {(PW*SEGMENTS){rd_ok_q}};
  assign fb.wr_ready    = idle_s;
  assign fb.cmd_ready   = idle_s;
  assign fb.swap_done   = swap_done_q;
  assign fb.active_bank = bank_q;

  // Command FSM: clear sweep of the back bank and frame-synchronous bank swap.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bank_d      = bank_q;
    swap_done_d = 1'b0;
    case (state_q)
      FB_IDLE: begin
        if (fb.clear_req) begin
          state_d   = FB_CLEAR;
          clr_cnt_d = {LW{1'b0}};
        end else if (fb.swap_req) begin
          state_d = FB_SWAP_WAIT;
        end else begin
          state_d = FB_IDLE;
        end
      end
      FB_CLEAR: begin
        if (clr_cnt_q == LAST) begin
          state_d   = FB_IDLE;
          clr_cnt_d = {LW{1'b0}};
        end else begin
          state_d   = FB_CLEAR;
          clr_cnt_d = clr_cnt_q + LW'(1);
        end
      end
      FB_SWAP_WAIT: begin
        if (fb.frame_complete) begin
          state_d     = FB_IDLE;
          bank_d      = ~bank_q;
          swap_done_d = 1'b1;
        end else begin
          state_d = FB_SWAP_WAIT;
        end
      end
      default: begin
        state_d = FB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FB_IDLE;
      clr_cnt_q   <= {LW{1'b0}};
      bank_q      <= 1'b0;
      swap_done_q <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bank_q      <= bank_d;
      swap_done_q <= swap_done_d;
      rd_ok_q     <= rd_in_range_s;
    end
  end

endmodule

// File: tb/tb_display_framebuffer.sv
// Self-checking bench for display_framebuffer: table-driven writes/reads plus
// randomized traffic checked against an array model of both banks.
module tb_display_framebuffer;
  import display_pkg::*;

  localparam int SEG  = 2;
  localparam int ROWS = 8;
  localparam int COLS = 32;
  localparam int BW   = 8;
  localparam int PW   = pixel_width(BW);
  localparam int NW   = ROWS * COLS;

  logic clk = 1'b0;
  logic rst;

  display_framebuffer_if #(.SEGMENTS(SEG), .ROWS(ROWS), .COLUMNS(COLS), .BITWIDTH(BW)) fb();

  display_framebuffer #(.SEGMENTS(SEG), .ROWS(ROWS), .COLUMNS(COLS), .BITWIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .fb  (fb)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] m_mem   [SEG][2][NW];
  bit            m_known [SEG][2][NW];
  bit            m_bank;
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    int            seg;
    int            row;
    int            col;
    logic [PW-1:0] data;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t tbl [8];
  int   ra_seg [24];
  int   ra_row [24];
  int   ra_col [24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mkpix(input int r, input int g, input int b);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    p[CH_R*BW +: BW] = BW'(r);
    p[CH_G*BW +: BW] = BW'(g);
    p[CH_B*BW +: BW] = BW'(b);
    return p;
  endfunction

  task automatic do_write(input int seg, input int row, input int col,
                          input logic [PW-1:0] d, input bit check_ready);
    fb.wr_valid   = 1'b1;
    fb.wr_segment = 1'(seg);
    fb.wr_row     = 3'(row);
    fb.wr_column  = 5'(col);
    fb.wr_data    = d;
    if (check_ready) chk("wr_ready_idle", fb.wr_ready, 1);
    step();
    fb.wr_valid = 1'b0;
    m_mem[seg][!m_bank][row*COLS + col]   = d;
    m_known[seg][!m_bank][row*COLS + col] = 1'b1;
  endtask

  // Issue one read; compare every segment whose word the model knows.
  task automatic chk_read(input int row, input int col, input string name);
    bit b;
    int a;
    fb.rd_row    = 3'(row);
    fb.rd_column = 5'(col);
    b = m_bank;
    a = (row % ROWS) * COLS + (col % COLS);
    step();
    for (int s = 0; s < SEG; s++) begin
      if (m_known[s][b][a]) chk(name, fb.rd_pixel[s*PW +: PW], m_mem[s][b][a]);
    end
  endtask

  task automatic swap(input int wait_cycles, input string name);
    fb.swap_req = 1'b1;
    step();
    fb.swap_req = 1'b0;
    repeat (wait_cycles) step();
    fb.frame_complete = 1'b1;
    step();
    fb.frame_complete = 1'b0;
    m_bank = !m_bank;
    chk({name, "_done"}, fb.swap_done, 1);
    chk({name, "_bank"}, fb.active_bank, 64'(m_bank));
    step();
    chk({name, "_done_low"}, fb.swap_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    fb.rd_row = 3'd0; fb.rd_column = 5'd0; fb.wr_valid = 1'b0; fb.wr_segment = 1'b0;
    fb.wr_row = 3'd0; fb.wr_column = 5'd0; fb.wr_data = {PW{1'b0}};
    fb.clear_req = 1'b0; fb.swap_req = 1'b0; fb.frame_complete = 1'b0;
    m_bank = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rd_pixel", fb.rd_pixel, 0);
    chk("rst_swap_done", fb.swap_done, 0);
    chk("rst_active_bank", fb.active_bank, 0);
    rst = 1'b0;
    step();
    chk("rst_cmd_ready", fb.cmd_ready, 1);
    chk("rst_wr_ready", fb.wr_ready, 1);

    // Table of writes into the back bank; entry 4 is overwritten by entry 5.
    tbl[0] = '{0, 2, 5,  24'h112233, 24'h112233};
    tbl[1] = '{1, 2, 5,  24'h445566, 24'h445566};
    tbl[2] = '{0, 0, 0,  24'h0000A5, 24'h0000A5};
    tbl[3] = '{1, 7, 31, 24'hFEDCBA, 24'hFEDCBA};
    tbl[4] = '{0, 4, 9,  24'h123456, 24'h654321};
    tbl[5] = '{0, 4, 9,  24'h654321, 24'h654321};
    tbl[6] = '{1, 6, 0,  24'h0, 24'h0};
    tbl[7] = '{0, 6, 17, 24'h0, 24'h0};
    for (int i = 6; i < 8; i++) begin
      tbl[i].col  = int'($urandom_range(COLS - 1, 1));
      tbl[i].data = mkpix(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
      tbl[i].exp  = tbl[i].data;
    end
    for (int i = 0; i < 8; i++) do_write(tbl[i].seg, tbl[i].row, tbl[i].col, tbl[i].data, 1'b1);
    swap(3, "swap1");
    for (int i = 0; i < 8; i++) begin
      fb.rd_row    = 3'(tbl[i].row);
      fb.rd_column = 5'(tbl[i].col);
      step();
      chk("tbl_read", fb.rd_pixel[tbl[i].seg*PW +: PW], tbl[i].exp);
    end

    // Random traffic into the back bank (bank 0), plus a known word at r2,c5.
    do_write(0, 2, 5, 24'hABCDEF, 1'b1);
    do_write(0, 1, 1, 24'h0F0F0F, 1'b1);
    for (int i = 0; i < 24; i++) begin
      ra_seg[i] = int'($urandom_range(SEG - 1));
      ra_row[i] = int'($urandom_range(ROWS - 1, 3));
      ra_col[i] = int'($urandom_range(COLS - 1));
      do_write(ra_seg[i], ra_row[i], ra_col[i], PW'($urandom), 1'b0);
    end

    // Swap held off for 100 cycles; writes during that window are refused.
    fb.swap_req = 1'b1;
    step();
    fb.swap_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c >= 40 && c < 50) begin
        fb.wr_valid = 1'b1; fb.wr_segment = 1'b0; fb.wr_row = 3'd1; fb.wr_column = 5'd1;
        fb.wr_data = 24'hDEAD00;
      end else begin
        fb.wr_valid = 1'b0;
      end
      chk("hold_ready_bank", {fb.wr_ready, fb.cmd_ready, fb.active_bank}, {2'b00, m_bank});
      step();
    end
    fb.wr_valid = 1'b0;
    fb.rd_row = 3'd2; fb.rd_column = 5'd5;
    fb.frame_complete = 1'b1;
    step();
    fb.frame_complete = 1'b0;
    chk("fc_cycle_read_old_bank", fb.rd_pixel[0 +: PW], 24'h112233);
    m_bank = !m_bank;
    chk("swap2_done", fb.swap_done, 1);
    chk("swap2_bank", fb.active_bank, 64'(m_bank));
    chk_read(2, 5, "new_front_r2c5");
    chk_read(1, 1, "refused_write");
    for (int i = 0; i < 24; i++) chk_read(ra_row[i], ra_col[i], "rand_read");

    // Fill back bank with white, then clear it and count busy cycles.
    for (int s = 0; s < SEG; s++)
      for (int a = 0; a < NW; a++) do_write(s, a / COLS, a % COLS, 24'hFFFFFF, 1'b0);
    fb.clear_req = 1'b1;
    step();
    fb.clear_req = 1'b0;
    n = 0;
    while (!fb.cmd_ready && n < 1000) begin
      n++;
      step();
    end
    chk("clear_busy_cycles", 64'(n), 64'(NW));
    for (int s = 0; s < SEG; s++)
      for (int a = 0; a < NW; a++) m_mem[s][!m_bank][a] = {PW{1'b0}};
    swap(2, "swap_clear");
    for (int a = 0; a < NW; a++) chk_read(a / COLS, a % COLS, "cleared_read");

    // clear_req and swap_req together: clear wins; frame_complete ignored while clearing.
    fb.clear_req = 1'b1; fb.swap_req = 1'b1;
    step();
    fb.clear_req = 1'b0; fb.swap_req = 1'b0;
    n = 0; seen = 1'b0;
    while (!fb.cmd_ready && n < 1000) begin
      fb.frame_complete = (n == 10) ? 1'b1 : 1'b0;
      n++;
      step();
      seen = seen | fb.swap_done;
    end
    fb.frame_complete = 1'b0;
    for (int s = 0; s < SEG; s++)
      for (int a = 0; a < NW; a++) m_mem[s][!m_bank][a] = {PW{1'b0}};
    chk("clr_swap_busy", 64'(n), 64'(NW));
    chk("clr_swap_no_done", seen, 0);
    chk("clr_swap_bank", fb.active_bank, 64'(m_bank));
    fb.frame_complete = 1'b1;
    step();
    fb.frame_complete = 1'b0;
    step();
    chk("idle_fc_no_swap", {fb.active_bank, fb.swap_done}, {m_bank, 1'b0});

    // Column sweep past the end of the row on both segments.
    for (int c = 0; c < COLS; c++)
      for (int s = 0; s < SEG; s++) do_write(s, 3, c, PW'($urandom), 1'b0);
    swap(1, "swap_sweep");
    for (int c = 0; c < COLS + 2; c++) chk_read(3, c, "sweep_read");

    // Asynchronous reset while waiting for a frame boundary.
    if (!m_bank) swap(0, "swap_pre_rst");
    fb.swap_req = 1'b1;
    step();
    fb.swap_req = 1'b0;
    repeat (5) step();
    chk("pre_rst_cmd_ready", fb.cmd_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bank", fb.active_bank, 0);
    chk("async_rst_swap_done", fb.swap_done, 0);
    chk("async_rst_rd_pixel", fb.rd_pixel, 0);
    step();
    rst = 1'b0;
    m_bank = 1'b0;
    step();
    chk("post_rst_cmd_ready", fb.cmd_ready, 1);
    chk("post_rst_bank", fb.active_bank, 0);
    chk_read(3, 4, "post_rst_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
